// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: default FIFO geometry and pointer-width helper shared by the FIFO slice
package syn_fifo_pkg;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_WIDTH_DEF = 8;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/syn_fifo_mem.sv
// syn_fifo_mem: DEPTH x WIDTH storage, synchronous write port, asynchronous read port
module syn_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/syn_fifo_core.sv
// syn_fifo_core: show-ahead single-clock FIFO; SYN_FIFO_ERR_FLAGS_EN adds sticky o_overflow/o_underflow
module syn_fifo_core
  import syn_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_full,
  output logic             o_empty
`ifdef SYN_FIFO_ERR_FLAGS_EN
  ,
  output logic             o_overflow,
  output logic             o_underflow
`endif
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  // MSB is the wrap bit: equal pointers mean empty, differing only in MSB means full
  assign o_empty = wr_ptr == rd_ptr;
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok   = i_wr_en & ~o_full;
  assign rd_ok   = i_rd_en & ~o_empty;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
`ifdef SYN_FIFO_ERR_FLAGS_EN
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_en & o_full)  o_overflow  <= 1'b1;
      if (i_rd_en & o_empty) o_underflow <= 1'b1;
    end
`endif
  syn_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .i_clk  (i_clk),
    .i_we   (wr_ok),
    .i_waddr(wr_ptr[AW-1:0]),
    .i_wdata(i_data_in),
    .i_raddr(rd_ptr[AW-1:0]),
    .o_rdata(o_data_out)
  );
endmodule

// File: tb/tb_syn_fifo_core.sv
// tb_syn_fifo_core: randomized and directed checks of syn_fifo_core against a queue model
module tb_syn_fifo_core;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  logic i_clk = 1'b0;
  logic i_rst_n, i_wr_en, i_rd_en;
  logic [WIDTH-1:0] i_data_in, o_data_out;
  logic o_full, o_empty;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q [$];
  logic m_ov, m_uf;
`ifdef SYN_FIFO_ERR_FLAGS_EN
  logic o_overflow, o_underflow;
`endif
  syn_fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
    .i_data_in(i_data_in), .o_data_out(o_data_out), .o_full(o_full), .o_empty(o_empty)
`ifdef SYN_FIFO_ERR_FLAGS_EN
    , .o_overflow(o_overflow), .o_underflow(o_underflow)
`endif
  );
  always #5 i_clk = ~i_clk;

  task automatic cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    was_full  = q.size() == DEPTH;
    was_empty = q.size() == 0;
    i_wr_en = wr; i_rd_en = rd; i_data_in = d;
    @(posedge i_clk); #1;
    if (wr && was_full) m_ov = 1'b1;
    if (rd && was_empty) m_uf = 1'b1;
    if (rd && !was_empty) void'(q.pop_front());
    if (wr && !was_full) q.push_back(d);
    i_wr_en = 1'b0; i_rd_en = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_data_in = '0;
    repeat (n) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    q.delete(); m_ov = 1'b0; m_uf = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", o_empty); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
    checks++; if ({o_overflow, o_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b%b exp 00", o_overflow, o_underflow); end
`endif
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i));
      checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got %b exp 0", i, o_empty); end
      checks++; if (o_full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full i=%0d got %b exp %b", i, o_full, i == DEPTH); end
    end
    cycle(1'b1, 1'b0, WIDTH'(17));
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_overwrite_full got %b exp 1", o_full); end
    checks++; if (o_data_out !== WIDTH'(1)) begin errors++; $display("FAIL fill_head got %0d exp 1", o_data_out); end
  endtask

  task automatic test_drain;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (o_data_out !== WIDTH'(i)) begin errors++; $display("FAIL drain_data i=%0d got %0d exp %0d", i, o_data_out, i); end
      cycle(1'b0, 1'b1, '0);
      checks++; if (o_empty !== (i == DEPTH)) begin errors++; $display("FAIL drain_empty i=%0d got %b exp %b", i, o_empty, i == DEPTH); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL drain_full i=%0d got %b exp 0", i, o_full); end
    end
    cycle(1'b0, 1'b1, '0);
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL drain_extra got e=%b f=%b exp e=1 f=0", o_empty, o_full); end
    cycle(1'b1, 1'b0, 8'hA5);
    checks++; if (o_data_out !== 8'hA5) begin errors++; $display("FAIL drain_after_underflow got %h exp a5", o_data_out); end
    cycle(1'b0, 1'b1, '0);
`ifdef SYN_FIFO_ERR_FLAGS_EN
    checks++; if ({o_overflow, o_underflow} !== {m_ov, m_uf}) begin errors++; $display("FAIL drain_err got %b%b exp %b%b", o_overflow, o_underflow, m_ov, m_uf); end
`endif
  endtask

  task automatic test_stream;
    cycle(1'b1, 1'b0, WIDTH'(1));
    for (int i = 2; i <= 6; i++) begin
      checks++; if (o_data_out !== WIDTH'(i - 1)) begin errors++; $display("FAIL stream_data i=%0d got %0d exp %0d", i, o_data_out, i - 1); end
      cycle(1'b1, 1'b1, WIDTH'(i));
      checks++; if (o_full !== 1'b0 || o_empty !== 1'b0) begin errors++; $display("FAIL stream_flags i=%0d got f=%b e=%b exp f=0 e=0", i, o_full, o_empty); end
    end
    checks++; if (o_data_out !== WIDTH'(6)) begin errors++; $display("FAIL stream_last got %0d exp 6", o_data_out); end
    cycle(1'b0, 1'b1, '0);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL stream_end_empty got %b exp 1", o_empty); end
  endtask

  task automatic test_wrap;
    int wcnt = 0;
    int guard = 0;
    for (int k = 0; k < 48; k++) begin
      if (q.size() != 0) begin
        checks++; if (o_data_out !== q[0]) begin errors++; $display("FAIL wrap_data k=%0d got %0d exp %0d", k, o_data_out, q[0]); end
      end
      cycle(wcnt < 24, (k % 3 == 2) || wcnt >= 24, WIDTH'(100 + wcnt));
      wcnt++;
      checks++; if (o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL wrap_flags k=%0d got e=%b f=%b occ=%0d", k, o_empty, o_full, q.size()); end
    end
    while (q.size() != 0 && guard < 64) begin
      checks++; if (o_data_out !== q[0]) begin errors++; $display("FAIL wrap_drain got %0d exp %0d", o_data_out, q[0]); end
      cycle(1'b0, 1'b1, '0);
      guard++;
    end
    checks++; if (o_empty !== 1'b1 || q.size() != 0) begin errors++; $display("FAIL wrap_final_empty got %b occ=%0d exp 1", o_empty, q.size()); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(50 + i));
    do_reset(1);
    checks++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin errors++; $display("FAIL mid_reset got e=%b f=%b exp e=1 f=0", o_empty, o_full); end
    cycle(1'b1, 1'b0, 8'h3C);
    checks++; if (o_data_out !== 8'h3C) begin errors++; $display("FAIL mid_reset_head got %h exp 3c", o_data_out); end
    cycle(1'b0, 1'b1, '0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 200; k++) begin
      logic wr, rd;
      wr = ($urandom_range(0, 99) < (k < 100 ? 65 : 35));
      rd = ($urandom_range(0, 99) < (k < 100 ? 35 : 65));
      if (q.size() != 0) begin
        checks++; if (o_data_out !== q[0]) begin errors++; $display("FAIL random_data k=%0d got %0d exp %0d", k, o_data_out, q[0]); end
      end
      cycle(wr, rd, WIDTH'($urandom));
      checks++; if (o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL random_flags k=%0d got e=%b f=%b occ=%0d", k, o_empty, o_full, q.size()); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
      checks++; if ({o_overflow, o_underflow} !== {m_ov, m_uf}) begin errors++; $display("FAIL random_err k=%0d got %b%b exp %b%b", k, o_overflow, o_underflow, m_ov, m_uf); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_stream;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
